// File: rtl/mt_seq_pkg.sv
// mt_seq_pkg
//   Shared types and constants for the MT frame-count sequencer:
//   - mt_seq_state_e : sequencer state encoding
//   - MT_FUNC_*      : tape function codes carried on func
//   - MT_FC_TERMINAL : MTFC value whose increment ends the count
//   - is_terminal()  : terminal-count test on an MTFC value
package mt_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAITRDY = 3'd2,
    ST_REQ     = 3'd3,
    ST_INC     = 3'd4,
    ST_SKIP    = 3'd5,
    ST_DONE    = 3'd6
  } mt_seq_state_e;

  localparam logic [1:0] MT_FUNC_WRITE = 2'b00;
  localparam logic [1:0] MT_FUNC_READ  = 2'b01;
  localparam logic [1:0] MT_FUNC_SPACE = 2'b10;
  localparam logic [1:0] MT_FUNC_RSVD  = 2'b11;

  localparam logic [15:0] MT_FC_TERMINAL = 16'hFFFF;

  // MTFC holds a negative count, so the unit moved while it reads FFFF is the last one.
  function automatic logic is_terminal(input logic [15:0] fc);
    return (fc == MT_FC_TERMINAL);
  endfunction

endpackage

// File: rtl/mt_frame_seq_if.sv
// mt_frame_seq_if
//   Bundles the function-decoder, tape-path, data-buffer and status signals
//   of the MT frame sequencer.
//   master : the surrounding MT logic (drives go/func/abort/mtFC/tape/buffer inputs)
//   slave  : the sequencer (drives bufREQ, mtINCFC, busy, done and status flags)
interface mt_frame_seq_if;

  logic        go;
  logic [1:0]  func;
  logic        abort;
  logic [15:0] mtFC;
  logic        frmRDY;
  logic        eor;
  logic        tmk;
  logic        bufACK;
  logic        bufREQ;
  logic        mtINCFC;
  logic        busy;
  logic        done;
  logic        fceERR;
  logic        tmkFLG;
  logic        shortREC;
  logic        toERR;

  modport master (
    output go, func, abort, mtFC, frmRDY, eor, tmk, bufACK,
    input  bufREQ, mtINCFC, busy, done, fceERR, tmkFLG, shortREC, toERR
  );

  modport slave (
    input  go, func, abort, mtFC, frmRDY, eor, tmk, bufACK,
    output bufREQ, mtINCFC, busy, done, fceERR, tmkFLG, shortREC, toERR
  );

endinterface

// File: rtl/mt_seq_wdog.sv
// mt_seq_wdog
//   Dwell-time counter for the sequencer watchdog.
//   clk, rst : clock, synchronous active-high reset
//   restart  : state is changing this cycle; counter reloads to zero
//   arm      : current state is one the watchdog guards
//   fire     : armed and this is cycle TIMEOUT spent in the current state
module mt_seq_wdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic arm,
  output logic fire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles spent in the current state, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fire = arm && (cnt_q == LIMIT);

endmodule

// File: rtl/mt_frame_seq.sv
// mt_frame_seq
//   Moves frames (WRITE/READ) or records (SPACE) one unit at a time between the
//   tape data path and the massbus data buffer, pulsing mtINCFC once per unit,
//   and reports busy/done/error status.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mt_frame_seq_if.slave
//              in : go, func, abort, mtFC, frmRDY, eor, tmk, bufACK
//              out: bufREQ, mtINCFC, busy, done, fceERR, tmkFLG, shortREC, toERR
//   Build option: define MT_SEQ_WATCHDOG_EN to include the TIMEOUT-cycle
//   watchdog on WAITRDY/REQ/SKIP; without it toERR stays 0.
module mt_frame_seq
  import mt_seq_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  mt_frame_seq_if.slave     bus
);

  mt_seq_state_e state_q, state_d;
  logic [1:0]    func_q, func_d;
  logic          eor_seen_q, eor_seen_d;
  logic          fce_q, fce_d;
  logic          tmk_q, tmk_d;
  logic          short_q, short_d;
  logic          to_q, to_d;
  logic          bufreq_q, bufreq_d;
  logic          inc_q, inc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          skip_inc_s;
  logic          is_read_s;
  logic          wdog_fire_s;

  assign is_read_s = (func_q == MT_FUNC_READ);

`ifdef MT_SEQ_WATCHDOG_EN
  logic wdog_arm_s;
  assign wdog_arm_s = (state_q == ST_WAITRDY) || (state_q == ST_REQ) || (state_q == ST_SKIP);

  mt_seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .restart (state_d != state_q),
    .arm     (wdog_arm_s),
    .fire    (wdog_fire_s)
  );
`else
  assign wdog_fire_s = 1'b0;
`endif

  // Next-state and sticky-flag logic; abort outranks every other event.
  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    eor_seen_d = eor_seen_q;
    fce_d      = fce_q;
    tmk_d      = tmk_q;
    short_d    = short_q;
    to_d       = to_q;
    skip_inc_s = 1'b0;

    if (bus.abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d = ST_DONE;
    end else if (wdog_fire_s) begin
      to_d    = 1'b1;
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.go) begin
            fce_d   = 1'b0;
            tmk_d   = 1'b0;
            short_d = 1'b0;
            to_d    = 1'b0;
            if (bus.func == MT_FUNC_RSVD) begin
              fce_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              func_d  = bus.func;
              state_d = ST_START;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          eor_seen_d = 1'b0;
          state_d    = (func_q == MT_FUNC_SPACE) ? ST_SKIP : ST_WAITRDY;
        end
        ST_WAITRDY: begin
          if (is_read_s && bus.tmk) begin
            tmk_d   = 1'b1;
            state_d = ST_DONE;
          end else if (is_read_s && bus.eor) begin
            short_d = 1'b1;
            state_d = ST_DONE;
          end else if (bus.frmRDY) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_WAITRDY;
          end
        end
        ST_REQ: begin
          if (is_read_s && bus.tmk) begin
            tmk_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            // An eor during the transfer is remembered; the frame still completes.
            if (is_read_s && bus.eor) begin
              eor_seen_d = 1'b1;
            end else begin
              eor_seen_d = eor_seen_q;
            end
            if (bus.bufACK) begin
              state_d = ST_INC;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
        ST_INC: begin
          if (is_terminal(bus.mtFC)) begin
            // READ with the record still running overruns: flag it and drain to eor.
            if (is_read_s && !(eor_seen_q || bus.eor)) begin
              fce_d   = 1'b1;
              state_d = ST_SKIP;
            end else begin
              state_d = ST_DONE;
            end
          end else if (is_read_s && (eor_seen_q || bus.eor)) begin
            short_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAITRDY;
          end
        end
        ST_SKIP: begin
          if (bus.tmk) begin
            tmk_d   = 1'b1;
            state_d = ST_DONE;
          end else if (bus.eor) begin
            if (func_q == MT_FUNC_SPACE) begin
              skip_inc_s = 1'b1;
              state_d    = is_terminal(bus.mtFC) ? ST_DONE : ST_SKIP;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    bufreq_d = (state_d == ST_REQ);
    inc_d    = (state_d == ST_INC) || skip_inc_s;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // State, latched function and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      func_q     <= 2'b00;
      eor_seen_q <= 1'b0;
      fce_q      <= 1'b0;
      tmk_q      <= 1'b0;
      short_q    <= 1'b0;
      to_q       <= 1'b0;
      bufreq_q   <= 1'b0;
      inc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      eor_seen_q <= eor_seen_d;
      fce_q      <= fce_d;
      tmk_q      <= tmk_d;
      short_q    <= short_d;
      to_q       <= to_d;
      bufreq_q   <= bufreq_d;
      inc_q      <= inc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.bufREQ   = bufreq_q;
  assign bus.mtINCFC  = inc_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.fceERR   = fce_q;
  assign bus.tmkFLG   = tmk_q;
  assign bus.shortREC = short_q;
  assign bus.toERR    = to_q;

endmodule

// File: tb/tb_mt_frame_seq.sv
// tb_mt_frame_seq
//   Scoreboard bench for mt_frame_seq: each function start pushes its expected
//   outcome; the done pulse pops and compares it.
module tb_mt_frame_seq;

  typedef struct {
    int   n_inc;
    logic fce;
    logic tmk;
    logic shrt;
    logic to;
    int   period;
    int   done_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mt_frame_seq_if bus();

  mt_frame_seq #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // MTFC register model: loads a start value, counts up on mtINCFC.
  logic        fc_load;
  logic [15:0] fc_init;
  logic [15:0] fc_model;
  always @(posedge clk) begin
    if (fc_load) fc_model <= fc_init;
    else if (bus.mtINCFC) fc_model <= fc_model + 16'd1;
  end
  assign bus.mtFC = fc_model;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cycle_n = 0;
  int   inc_cnt = 0;
  int   last_inc = 0;
  int   mark_cycle = 0;
  bit   done_seen = 1'b0;
  bit   ack_auto = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(int n, logic f, logic t, logic s, logic o, int p, int l);
    exp_t e;
    e.n_inc = n; e.fce = f; e.tmk = t; e.shrt = s; e.to = o; e.period = p; e.done_lat = l;
    return e;
  endfunction

  // One clock: sample outputs at the falling edge, score them, answer bufREQ.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cycle_n++;
    if (bus.mtINCFC) begin
      if (sb.size() > 0 && sb[0].period != 0 && inc_cnt > 0)
        chk("inc_period", cycle_n - last_inc, sb[0].period);
      inc_cnt++;
      last_inc   = cycle_n;
      mark_cycle = cycle_n;
    end
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("inc_count", inc_cnt, e.n_inc);
        chk("fceERR", bus.fceERR, e.fce);
        chk("tmkFLG", bus.tmkFLG, e.tmk);
        chk("shortREC", bus.shortREC, e.shrt);
        chk("toERR", bus.toERR, e.to);
        chk("busy_at_done", bus.busy, 32'd1);
        if (e.done_lat != 0) chk("done_latency", cycle_n - mark_cycle, e.done_lat);
      end
      done_seen = 1'b1;
    end
    bus.bufACK = ack_auto & bus.bufREQ;
  endtask

  task automatic start(input logic [1:0] f, input logic [15:0] fc, input exp_t e);
    fc_init = fc;
    fc_load = 1'b1;
    cyc();
    fc_load   = 1'b0;
    inc_cnt   = 0;
    done_seen = 1'b0;
    sb.push_back(e);
    bus.func = f;
    bus.go   = 1'b1;
    mark_cycle = cycle_n;
    cyc();
    bus.go = 1'b0;
    chk("busy_after_go", bus.busy, 32'd1);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && !done_seen; i++) cyc();
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    bus.go = 1'b0; bus.func = 2'b00; bus.abort = 1'b0; bus.frmRDY = 1'b1;
    bus.eor = 1'b0; bus.tmk = 1'b0; bus.bufACK = 1'b0;
    fc_load = 1'b1; fc_init = 16'h0000;
    repeat (3) cyc();
    rst = 1'b0;
    fc_load = 1'b0;
    cyc();
    chk("reset_outs", {bus.busy, bus.done, bus.bufREQ, bus.mtINCFC,
                       bus.fceERR, bus.tmkFLG, bus.shortREC, bus.toERR}, 32'd0);

    // WRITE, three frames back to back: 3-cycle spacing, done one cycle after the last.
    start(2'b00, 16'hFFFD, mk(3, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1));
    wait_done(50);

    // READ, record of 4 frames inside a count of 16: short record.
    start(2'b01, 16'hFFF0, mk(4, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0));
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (inc_cnt == 4) begin
        bus.eor = 1'b1; bus.frmRDY = 1'b0;
        cyc();
        bus.eor = 1'b0;
        break;
      end
    end
    wait_done(20);
    bus.frmRDY = 1'b1;

    // READ, count of 2 against a 5-frame record: overrun, drain to eor.
    start(2'b01, 16'hFFFE, mk(2, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0));
    for (int i = 0; i < 40 && !bus.fceERR; i++) cyc();
    repeat (3) cyc();
    chk("skip_no_req", bus.bufREQ, 32'd0);
    chk("skip_busy", bus.busy, 32'd1);
    bus.eor = 1'b1;
    cyc();
    bus.eor = 1'b0;
    wait_done(20);

    // SPACE with count 0 (65536): three records then a tape mark.
    start(2'b10, 16'h0000, mk(3, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0));
    for (int r = 0; r < 3; r++) begin
      cyc();
      bus.eor = 1'b1;
      cyc();
      bus.eor = 1'b0;
      cyc();
      cyc();
    end
    bus.tmk = 1'b1;
    cyc();
    bus.tmk = 1'b0;
    wait_done(20);

    // Abort during REQ with a coincident bufACK; an earlier go while busy is ignored.
    ack_auto = 1'b0;
    start(2'b00, 16'hFFF0, mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1));
    for (int i = 0; i < 20 && !bus.bufREQ; i++) cyc();
    bus.func = 2'b11;
    bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    chk("req_held", bus.bufREQ, 32'd1);
    bus.abort = 1'b1;
    bus.bufACK = 1'b1;
    mark_cycle = cycle_n;
    cyc();
    bus.abort = 1'b0;
    chk("abort_drops_req", bus.bufREQ, 32'd0);
    ack_auto = 1'b1;
    wait_done(5);
    repeat (4) cyc();
    chk("idle_after_abort", bus.busy, 32'd0);

    // Reserved function code.
    start(2'b11, 16'hFFF0, mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    wait_done(5);

    // Reset in the middle of a WRITE.
    start(2'b00, 16'hFFF0, mk(99, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_outs", {bus.busy, bus.done, bus.bufREQ, bus.mtINCFC,
                         bus.fceERR, bus.tmkFLG, bus.shortREC, bus.toERR}, 32'd0);
    sb.delete();
    repeat (3) cyc();
    chk("rst_mid_idle", {bus.busy, bus.mtINCFC}, 32'd0);

`ifdef MT_SEQ_WATCHDOG_EN
    // Tape path never ready: watchdog fires on cycle 16 of WAITRDY.
    bus.frmRDY = 1'b0;
    start(2'b00, 16'hFFF0, mk(0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 18));
    wait_done(40);
    bus.frmRDY = 1'b1;
`endif

    repeat (3) cyc();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mt_frame_seq.md
# mt_frame_seq

Sequencer for the MT frame count register. It accepts a tape function (WRITE, READ, SPACE), moves frames or records one at a time between the tape data path and the massbus data buffer, and pulses mtINCFC once per unit moved. It terminates on frame-count wrap to zero, on end of record, on tape mark, or on abort. It sits between the MT function decoder and the MTFC register and data buffer, and supplies busy, done and error status to the MT status registers.

## Interface
- TIMEOUT, default 4096: watchdog limit in clk cycles. Used only when the watchdog is compiled in.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- go  in  1  one-cycle start strobe
- func  in  2  function code: 00 WRITE, 01 READ, 10 SPACE, 11 reserved
- abort  in  1  stop the current function
- mtFC  in  16  current MTFC value, two's-complement negative count
- frmRDY  in  1  tape path ready: a frame is available (READ) or can be accepted (WRITE)
- eor  in  1  end-of-record strobe from the tape path
- tmk  in  1  tape-mark-detected strobe
- bufACK  in  1  data buffer completed one frame
- bufREQ  out  1  request one frame transfer from the data buffer
- mtINCFC  out  1  increment MTFC, one cycle per unit
- busy  out  1  function in progress
- done  out  1  one-cycle completion pulse
- fceERR  out  1  frame-count error, sticky until next go
- tmkFLG  out  1  tape mark seen, sticky until next go
- shortREC  out  1  record ended before terminal count, sticky until next go
- toERR  out  1  watchdog timeout, sticky until next go; tied 0 when the watchdog is compiled out

## Operation
- States: IDLE, START, WAITRDY, REQ, INC, SKIP, DONE.
- IDLE
  - go with func 00, 01 or 10 → START; clears fceERR, tmkFLG, shortREC, toERR.
  - go with func 11 → DONE with fceERR set.
  - go while busy is ignored.
- START: latch func; clear the internal moved flag. WRITE and READ → WAITRDY; SPACE → SKIP.
- WAITRDY: frmRDY → REQ. READ only: eor → DONE with shortREC set; tmk → DONE with tmkFLG set.
- REQ: hold bufREQ until bufACK, then → INC.
- INC: assert mtINCFC for one cycle and set moved.
  - If mtFC == 16'hFFFF (terminal count): WRITE → DONE; READ → SKIP with fceERR set when no eor has arrived by this cycle, else → DONE.
  - Otherwise → WAITRDY.
- SKIP: each eor (SPACE) pulses mtINCFC; the terminal count rule is the same as in INC.
  - SPACE: tmk → DONE with tmkFLG set.
  - READ (entered via terminal-count overrun): discard frames until eor, then → DONE.
- DONE: pulse done for one cycle → IDLE.
- mtFC == 0 at go means 65536 units. Terminal count is detected only on the increment from FFFF, never from the initial value.
- abort in any non-IDLE state → DONE next cycle and drops bufREQ. An in-flight bufACK in that cycle does not increment.
- Priority: rst > abort > tmk > eor > bufACK/frmRDY.

## Timing
- Reset values: all outputs 0; state IDLE.
- busy is high from the cycle after go through the done cycle inclusive.
- go → first bufREQ: at least 3 cycles (START, WAITRDY with frmRDY high, REQ).
- bufACK → mtINCFC: 1 cycle. MTFC updates on the edge ending the INC cycle.
- Minimum per-frame period: 3 cycles (WAITRDY, REQ, INC) when frmRDY and bufACK are immediate.
- Terminal count → done: 1 cycle for WRITE.
- rst mid-function: IDLE and all outputs 0 on the next edge; no mtINCFC is issued.

## Configuration
- MT_SEQ_WATCHDOG_EN
  - Defined: a counter reloads on every state change. If it reaches TIMEOUT in WAITRDY, REQ or SKIP, the block sets toERR and goes to DONE.
  - Undefined: the counter is removed, toERR is tied 0, and the block waits indefinitely.

## Structure
- Package mt_seq_pkg holds:
  - the state enum;
  - function codes MT_FUNC_WRITE, MT_FUNC_READ, MT_FUNC_SPACE;
  - the terminal count constant 16'hFFFF.
- Sub-module mt_seq_wdog holds the watchdog counter, instantiated only under MT_SEQ_WATCHDOG_EN.

## Test plan
- WRITE, mtFC=16'hFFFD, frmRDY and bufACK immediate → exactly 3 mtINCFC pulses, 3 cycles apart; done 1 cycle after the third; no errors.
- READ, mtFC=16'hFFF0, eor after 4 frames → 4 increments, shortREC=1, done, fceERR=0.
- READ, mtFC=16'hFFFE, record of 5 frames → 2 increments, fceERR=1, remaining frames discarded, done after eor.
- SPACE, mtFC=0, tmk after 3 eor → 3 increments, tmkFLG=1, done; no terminal-count exit.
- abort while bufREQ is high with a simultaneous bufACK → no mtINCFC, done next cycle; a second go during busy is ignored.
- With MT_SEQ_WATCHDOG_EN and TIMEOUT=16, frmRDY held low → toERR=1 and done at cycle 16 of WAITRDY.
